// File: rtl/bf_pkg.sv
// bf_pkg: shared definitions for the BF machine control path.
//   - Opcode encodings as stored in program memory.
//   - Loop-sequencer FSM state type.
//   - Loop-sequencer error codes.
package bf_pkg;

    localparam logic [3:0] OP_END   = 4'h0;
    localparam logic [3:0] OP_INC   = 4'h1;
    localparam logic [3:0] OP_DEC   = 4'h2;
    localparam logic [3:0] OP_RIGHT = 4'h3;
    localparam logic [3:0] OP_LEFT  = 4'h4;
    localparam logic [3:0] OP_LBR   = 4'h5;
    localparam logic [3:0] OP_RBR   = 4'h6;
    localparam logic [3:0] OP_OUT   = 4'h7;
    localparam logic [3:0] OP_IN    = 4'h8;

    typedef enum logic [2:0] {
        StIdle,
        StScanIssue,
        StScanCheck,
        StFinish,
        StError
    } loopStateT;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
    localparam logic [1:0] ERR_UNMATCHED = 2'b11;

endpackage

// File: rtl/bf_addr_stack.sv
// bf_addr_stack: register-based LIFO holding loop return addresses.
// Ports:
//   clock, reset    rising-edge clock, asynchronous active-high reset (clears pointer only)
//   push, pop       push wins if both asserted; push when full / pop when empty are ignored
//   wrData          value to push
//   top             most recently pushed entry (undefined when empty)
//   depth           number of valid entries
//   full, empty     occupancy flags
module bf_addr_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned SAW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] top,
    output logic [SAW:0]     depth,
    output logic             full,
    output logic             empty
);

    localparam logic [SAW:0] DEPTH_CNT = (SAW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SAW:0]     sp;
    logic [SAW-1:0]   topIdx;

    assign full   = (sp == DEPTH_CNT);
    assign empty  = (sp == '0);
    assign depth  = sp;
    assign topIdx = SAW'(sp - 1'b1);
    assign top    = mem[topIdx];

    // Contents need no reset: only entries below sp are ever read.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[sp[SAW-1:0]] <= wrData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

endmodule

// File: rtl/bf_loop_ctrl.sv
// bf_loop_ctrl: loop/branch sequencer for the BF '[' and ']' instructions.
// Backward jumps come from a hardware return-address stack; skipped loops
// trigger a forward bracket-matching scan over program memory.
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   start              request pulse, sampled only in IDLE with no sticky error
//   op, pc, data_zero  opcode at pc, its address, and current-cell-is-zero flag
//   pm_q               program-memory read data (1-cycle latency)
//   pm_addr, pm_sel    scan read address and mux select towards program memory
//   busy               request in progress
//   done, pc_load      completion pulse; pc_load accompanies it when no error
//   pc_next            next PC, valid with done
//   depth              stack occupancy
//   err, err_code      sticky error flag and cause
// Build option: define BF_PIPE_SCAN_EN to issue one scan read per cycle.
module bf_loop_ctrl
    import bf_pkg::*;
#(
    parameter int unsigned PMAW        = 8,
    parameter int unsigned STACK_DEPTH = 16,
    parameter int unsigned SAW         = $clog2(STACK_DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [PMAW-1:0] pc,
    input  logic            data_zero,
    input  logic [3:0]      pm_q,
    output logic [PMAW-1:0] pm_addr,
    output logic            pm_sel,
    output logic            busy,
    output logic            done,
    output logic            pc_load,
    output logic [PMAW-1:0] pc_next,
    output logic [SAW:0]    depth,
    output logic            err,
    output logic [1:0]      err_code
);

    localparam logic [SAW+1:0] NEST_ONE = 1;

    loopStateT         state;
    logic [PMAW-1:0]   scanPtr;
    logic [SAW+1:0]    nest;
    logic [PMAW-1:0]   stackTop;
    logic              stackFull;
    logic              stackEmpty;
    logic              accept;
    logic              push;
    logic              pop;

    assign accept = (state == StIdle) && start && !err;
    assign push   = accept && (op == OP_LBR) && !data_zero && !stackFull;
    assign pop    = accept && (op == OP_RBR) && data_zero && !stackEmpty;

    bf_addr_stack #(
        .WIDTH (PMAW),
        .DEPTH (STACK_DEPTH),
        .SAW   (SAW)
    ) uStack (
        .clock  (clock),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .wrData (pc),
        .top    (stackTop),
        .depth  (depth),
        .full   (stackFull),
        .empty  (stackEmpty)
    );

    // The error cycle is not reported as busy, so busy stays low from then on.
    assign busy   = (state != StIdle) && !err;
    assign pm_sel = (state == StScanIssue) || (state == StScanCheck);

`ifdef BF_PIPE_SCAN_EN
    // While checking location n, the read for n+1 is already in flight.
    assign pm_addr = (state == StScanCheck) ? scanPtr + 1'b1 : scanPtr;
`else
    assign pm_addr = scanPtr;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            scanPtr  <= '0;
            nest     <= '0;
            done     <= 1'b0;
            pc_load  <= 1'b0;
            pc_next  <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            done    <= 1'b0;
            pc_load <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        if (op == OP_LBR && data_zero) begin
                            scanPtr <= pc + 1'b1;
                            nest    <= NEST_ONE;
                            state   <= StScanIssue;
                        end else if ((op == OP_LBR && stackFull) ||
                                     (op == OP_RBR && stackEmpty)) begin
                            state    <= StError;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            err_code <= (op == OP_LBR) ? ERR_OVERFLOW : ERR_UNDERFLOW;
                        end else begin
                            state   <= StFinish;
                            done    <= 1'b1;
                            pc_load <= 1'b1;
                            pc_next <= (op == OP_RBR && !data_zero) ? stackTop + 1'b1
                                                                     : pc + 1'b1;
                        end
                    end
                end
                StScanIssue: begin
                    state <= StScanCheck;
                end
                StScanCheck: begin
                    if (pm_q == OP_RBR && nest == NEST_ONE) begin
                        state   <= StFinish;
                        done    <= 1'b1;
                        pc_load <= 1'b1;
                        pc_next <= scanPtr + 1'b1;
                    end else if (pm_q == OP_END || scanPtr == '1 ||
                                 (pm_q == OP_LBR && nest == '1)) begin
                        // Nesting-counter overflow outranks running off the end.
                        state    <= StError;
                        done     <= 1'b1;
                        err      <= 1'b1;
                        err_code <= (pm_q == OP_LBR && nest == '1) ? ERR_OVERFLOW
                                                                    : ERR_UNMATCHED;
                    end else begin
                        if (pm_q == OP_LBR) begin
                            nest <= nest + 1'b1;
                        end else if (pm_q == OP_RBR) begin
                            nest <= nest - 1'b1;
                        end
                        scanPtr <= scanPtr + 1'b1;
`ifdef BF_PIPE_SCAN_EN
                        state <= StScanCheck;
`else
                        state <= StScanIssue;
`endif
                    end
                end
                StFinish: begin
                    state <= StIdle;
                end
                StError: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_loop_ctrl.sv
// Scoreboard bench for bf_loop_ctrl: the stimulus side computes each expected
// response from a queue-based stack model and a program-memory array, and a
// monitor compares every done pulse against the oldest expectation.
module tb_bf_loop_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] op = 4'h0;
    logic [7:0] pcIn = 8'h0;
    logic       dz = 1'b0;
    logic [3:0] pm_q;
    logic [7:0] pm_addr;
    logic       pm_sel;
    logic       busy;
    logic       done;
    logic       pc_load;
    logic [7:0] pc_next;
    logic [4:0] depth;
    logic       err;
    logic [1:0] err_code;

    typedef struct {
        bit pcLoad;
        int pcNext;
        int depth;
        bit err;
        int errCode;
        int doneCyc;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [3:0] pmem [256];
    exp_t       expQ[$];
    exp_t       monE;
    int         stk[$];
    bit         mErr = 1'b0;
    int         mErrCode = 0;

    bf_loop_ctrl dut (
        .clock     (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .pc        (pcIn),
        .data_zero (dz),
        .pm_q      (pm_q),
        .pm_addr   (pm_addr),
        .pm_sel    (pm_sel),
        .busy      (busy),
        .done      (done),
        .pc_load   (pc_load),
        .pc_next   (pc_next),
        .depth     (depth),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Synchronous program memory with the same address mux as the top level.
    always @(posedge clk) pm_q <= pmem[pm_sel ? pm_addr : pcIn];

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no response (cycle %0d)", cyc);
            end else begin
                monE = expQ.pop_front();
                chk("done_cycle", cyc, monE.doneCyc);
                chk("pc_load", int'(pc_load), int'(monE.pcLoad));
                if (monE.pcLoad) chk("pc_next", int'(pc_next), monE.pcNext);
                chk("depth", int'(depth), monE.depth);
                chk("err", int'(err), int'(monE.err));
                chk("err_code", int'(err_code), monE.errCode);
            end
        end
    end

    // Called #1 after a rising edge with the DUT idle; returns #1 after the
    // edge that sampled start.
    task automatic startReq(input int o, input int p, input bit d);
        exp_t e;
        int a, nest, k, o2, lat;
        bit fin;
        e = '{default: 0};
        if (!mErr) begin
            e.pcLoad = 1'b1;
            e.pcNext = (p + 1) % 256;
            k = 0;
            if (o == 5 && !d) begin
                if (stk.size() == 16) begin
                    e.pcLoad = 1'b0; mErr = 1'b1; mErrCode = 1;
                end else begin
                    stk.push_back(p);
                end
            end else if (o == 5) begin
                a = (p + 1) % 256; nest = 1; k = 1; fin = 1'b0;
                while (!fin) begin
                    o2 = int'(pmem[a]);
                    if (o2 == 6 && nest == 1) begin
                        e.pcNext = (a + 1) % 256; fin = 1'b1;
                    end else if (o2 == 0) begin
                        e.pcLoad = 1'b0; mErr = 1'b1; mErrCode = 3; fin = 1'b1;
                    end else if (o2 == 5 && nest == 63) begin
                        e.pcLoad = 1'b0; mErr = 1'b1; mErrCode = 1; fin = 1'b1;
                    end else if (a == 255) begin
                        e.pcLoad = 1'b0; mErr = 1'b1; mErrCode = 3; fin = 1'b1;
                    end else begin
                        nest += (o2 == 5) ? 1 : ((o2 == 6) ? -1 : 0);
                        a++;
                        k++;
                    end
                end
            end else if (o == 6) begin
                if (stk.size() == 0) begin
                    e.pcLoad = 1'b0; mErr = 1'b1; mErrCode = 2;
                end else if (!d) begin
                    e.pcNext = (stk[$] + 1) % 256;
                end else begin
                    void'(stk.pop_back());
                end
            end
`ifdef BF_PIPE_SCAN_EN
            lat = (k == 0) ? 0 : k + 1;
`else
            lat = 2 * k;
`endif
            e.depth   = stk.size();
            e.err     = mErr;
            e.errCode = mErrCode;
            e.doneCyc = cyc + 1 + lat;
            expQ.push_back(e);
        end
        op    = 4'(o);
        pcIn  = 8'(p);
        dz    = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 1200 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        stk.delete();
        expQ.delete();
        mErr = 1'b0;
        mErrCode = 0;
    endtask

    task automatic randPmem();
        int r;
        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      pmem[i] = 4'h0;
            else if (r < 5)  pmem[i] = 4'h5;
            else if (r < 10) pmem[i] = 4'h6;
            else             pmem[i] = 4'($urandom_range(1, 4));
        end
    endtask

    initial begin
        int o, r;
        for (int i = 0; i < 256; i++) pmem[i] = 4'h1;

        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pc_load", int'(pc_load), 0);
        chk("rst_pc_next", int'(pc_next), 0);
        chk("rst_depth", int'(depth), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_pm_sel", int'(pm_sel), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Enter loop, iterate, then exit.
        startReq(5, 3, 1'b0); waitDone();
        startReq(6, 9, 1'b0); waitDone();
        startReq(6, 9, 1'b1); waitDone();

        // Skip a nested loop: closing bracket of pc 0 sits at address 5.
        pmem[1] = 4'h5; pmem[2] = 4'h2; pmem[3] = 4'h6; pmem[4] = 4'h1; pmem[5] = 4'h6;
        startReq(5, 0, 1'b1);
        chk("scan_pm_sel", int'(pm_sel), 1);
        chk("scan_pm_addr", int'(pm_addr), 1);
        chk("scan_busy", int'(busy), 1);
        waitDone();

        // Underflow, then a start that must be ignored.
        startReq(6, 9, 1'b1); waitDone();
        startReq(5, 4, 1'b0);
        chk("ignored_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("sticky_err", int'(err), 1);
        chk("sticky_err_code", int'(err_code), 2);
        doReset();

        // Overflow on the 17th push.
        for (int i = 0; i < 17; i++) begin
            startReq(5, 40 + i, 1'b0);
            waitDone();
        end
        doReset();

        // Unmatched bracket hits OP_END at address 2.
        pmem[1] = 4'h2; pmem[2] = 4'h0;
        startReq(5, 0, 1'b1); waitDone();
        doReset();

        // Reset in the middle of a scan with a non-empty stack.
        startReq(5, 10, 1'b0); waitDone();
        startReq(5, 20, 1'b0); waitDone();
        startReq(5, 0, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midscan_busy", int'(busy), 0);
        chk("midscan_depth", int'(depth), 0);
        chk("midscan_pm_sel", int'(pm_sel), 0);
        doReset();

        // Randomized requests against the model.
        randPmem();
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      o = 5;
            else if (r < 7) o = 6;
            else if (r == 7) o = 0;
            else            o = $urandom_range(1, 8);
            if (mErr) begin
                startReq(o, $urandom_range(0, 255), 1'($urandom_range(0, 1)));
                chk("rand_ignored_busy", int'(busy), 0);
                repeat (2) @(posedge clk);
                #1;
                doReset();
                randPmem();
            end else begin
                startReq(o, $urandom_range(0, 255), 1'($urandom_range(0, 1)));
                waitDone();
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
